// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - raster timing generator with runtime-selectable test patterns
module video_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CW         = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int BAR_W      = 16
) (
  input  logic          clk_25m,
  input  logic          rst_n,
  input  logic [2:0]    mode,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [11:0]   x,
  output logic [10:0]   y,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= 4096) begin : g_bad_h_total
    $error("H_TOTAL must be below 4096");
  end
  if (V_TOTAL >= 2048) begin : g_bad_v_total
    $error("V_TOTAL must be below 2048");
  end

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG    = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_LAST  = 12'(H_ACTIVE - 1);
  localparam logic [12:0] BAR_WIDTH = 13'(BAR_W);
  localparam logic [11:0] BAR_STEP  = 12'(H_ACTIVE / 8);
  localparam logic [11:0] THIRD_1   = 12'(H_ACTIVE / 3);
  localparam logic [11:0] THIRD_2   = 12'((2 * H_ACTIVE) / 3);

  logic [11:0]   h_cnt_q, h_cnt_d;
  logic [10:0]   v_cnt_q, v_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [11:0]   bar_pos_q, bar_pos_d;
  logic [2:0]    mode_q, mode_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          fs_q, fs_d;
  logic [11:0]   x_q, x_d;
  logic [10:0]   y_q, y_d;
  logic [CW-1:0] red_q, red_d;
  logic [CW-1:0] green_q, green_d;
  logic [CW-1:0] blue_q, blue_d;

  logic          h_last, v_last, at_origin, active, hs_act, vs_act, in_bar;
  logic [11:0]   bar_idx;
  logic [2:0]    rgb_on;
  logic          ramp_sel;

  assign h_last    = (h_cnt_q == H_LAST);
  assign v_last    = (v_cnt_q == V_LAST);
  assign at_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);
  assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_act    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs_act    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  assign bar_idx   = h_cnt_q / BAR_STEP;
  // bar shape is clipped at the right edge by the active-region mask, never wrapped
  assign in_bar    = ({1'b0, h_cnt_q} >= {1'b0, bar_pos_q}) &&
                     ({1'b0, h_cnt_q} < ({1'b0, bar_pos_q} + BAR_WIDTH));

  // raster counters; frame count, bar position and pattern select change only at the frame boundary
  always_comb begin
    h_cnt_d     = h_last ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    bar_pos_d   = bar_pos_q;
    if (h_last) begin
      v_cnt_d = v_last ? 11'd0 : v_cnt_q + 11'd1;
    end
    if (h_last && v_last) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      bar_pos_d   = (bar_pos_q == BAR_LAST) ? 12'd0 : bar_pos_q + 12'd1;
    end
    // the pixel at (0,0) already uses the freshly sampled mode
    mode_d = at_origin ? mode : mode_q;
  end

  // pattern selection as on/off per channel ({r,g,b}), except the grey ramp
  always_comb begin
    rgb_on   = 3'b000;
    ramp_sel = 1'b0;
    case (mode_d)
      3'd0: begin
        case (bar_idx)
          12'd0:   rgb_on = 3'b111;
          12'd1:   rgb_on = 3'b110;
          12'd2:   rgb_on = 3'b011;
          12'd3:   rgb_on = 3'b010;
          12'd4:   rgb_on = 3'b101;
          12'd5:   rgb_on = 3'b100;
          12'd6:   rgb_on = 3'b001;
          default: rgb_on = 3'b000;
        endcase
      end
      // top-left square is white
      3'd1:    rgb_on   = {3{h_cnt_q[CHECK_LOG2] ~^ v_cnt_q[CHECK_LOG2]}};
      3'd2:    ramp_sel = 1'b1;
      3'd3:    rgb_on   = in_bar ? 3'b111 : 3'b001;
      3'd4: begin
        if (h_cnt_q < THIRD_1)      rgb_on = 3'b100;
        else if (h_cnt_q < THIRD_2) rgb_on = 3'b010;
        else                        rgb_on = 3'b001;
      end
      default: rgb_on = 3'b000;
    endcase
  end

  // output stage: everything derived from the same counter state so it lines up one cycle later
  always_comb begin
    hsync_d = hs_act ? HS_POL : ~HS_POL;
    vsync_d = vs_act ? VS_POL : ~VS_POL;
    de_d    = active;
    x_d     = h_cnt_q;
    y_d     = v_cnt_q;
    fs_d    = at_origin;
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active) begin
      if (ramp_sel) begin
        red_d   = h_cnt_q[CW-1:0];
        green_d = h_cnt_q[CW-1:0];
        blue_d  = h_cnt_q[CW-1:0];
      end else begin
        red_d   = {CW{rgb_on[2]}};
        green_d = {CW{rgb_on[1]}};
        blue_d  = {CW{rgb_on[0]}};
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      bar_pos_q   <= '0;
      mode_q      <= '0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      bar_pos_q   <= bar_pos_d;
      mode_q      <= mode_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      x_q         <= x_d;
      y_q         <= y_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - directed vector bench for video_pattern_gen
module tb_video_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  mode_a, mode_b;
  logic        hsync_a, vsync_a, de_a, frame_start_a;
  logic [11:0] x_a;
  logic [10:0] y_a;
  logic [7:0]  red_a, green_a, blue_a;
  logic [15:0] frame_cnt_a;
  logic        hsync_b, vsync_b, de_b, frame_start_b;
  logic [11:0] x_b;
  logic [10:0] y_b;
  logic [3:0]  red_b, green_b, blue_b;
  logic [15:0] frame_cnt_b;

  // 22 x 7 raster, 154 clocks per frame
  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(8), .CHECK_LOG2(1), .BAR_W(3)
  ) dut_a (
    .clk_25m(clk), .rst_n(rst_n), .mode(mode_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .x(x_a), .y(y_a),
    .red(red_a), .green(green_a), .blue(blue_a),
    .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
  );

  // 26 x 7 raster, width not a multiple of 8, 4-bit colour
  video_pattern_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(4), .CHECK_LOG2(2), .BAR_W(4)
  ) dut_b (
    .clk_25m(clk), .rst_n(rst_n), .mode(mode_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
    .red(red_b), .green(green_b), .blue(blue_b),
    .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
  );

  bit          sel;
  logic        s_de, s_fs;
  logic [11:0] s_x;
  logic [10:0] s_y;
  logic [7:0]  s_r, s_g, s_b;

  always_comb begin
    s_de = de_a; s_fs = frame_start_a; s_x = x_a; s_y = y_a;
    s_r = red_a; s_g = green_a; s_b = blue_a;
    if (sel) begin
      s_de = de_b; s_fs = frame_start_b; s_x = x_b; s_y = y_b;
      s_r = {4'h0, red_b}; s_g = {4'h0, green_b}; s_b = {4'h0, blue_b};
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_fs && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!s_fs) begin
      checks++; errors++;
      $display("FAIL %s frame_start timeout actual=none required=pulse", tag);
    end
  endtask

  task automatic wait_pixel(input string tag, input int px, input int py);
    int n;
    n = 0;
    while (!(s_de && s_x == 12'(px) && s_y == 11'(py)) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!(s_de && s_x == 12'(px) && s_y == 11'(py))) begin
      checks++; errors++;
      $display("FAIL %s pixel timeout actual=none required=(%0d,%0d)", tag, px, py);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit         sel;
    logic [2:0] md;
    int         px;
    int         py;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit s, input logic [2:0] m, input int px, input int py,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    vec_t v;
    v.sel = s; v.md = m; v.px = px; v.py = py; v.r = r; v.g = g; v.b = b;
    vecs.push_back(v);
  endtask

  initial begin
    // dut_a: bars 2 px wide, checker 2 px, thirds at 5/10
    add(0, 3'd0,  0, 0, 8'hFF, 8'hFF, 8'hFF);
    add(0, 3'd0,  2, 1, 8'hFF, 8'hFF, 8'h00);
    add(0, 3'd0,  5, 2, 8'h00, 8'hFF, 8'hFF);
    add(0, 3'd0,  6, 0, 8'h00, 8'hFF, 8'h00);
    add(0, 3'd0,  9, 3, 8'hFF, 8'h00, 8'hFF);
    add(0, 3'd0, 10, 0, 8'hFF, 8'h00, 8'h00);
    add(0, 3'd0, 13, 1, 8'h00, 8'h00, 8'hFF);
    add(0, 3'd0, 15, 3, 8'h00, 8'h00, 8'h00);
    add(0, 3'd1,  0, 0, 8'hFF, 8'hFF, 8'hFF);
    add(0, 3'd1,  2, 0, 8'h00, 8'h00, 8'h00);
    add(0, 3'd1,  2, 2, 8'hFF, 8'hFF, 8'hFF);
    add(0, 3'd1,  1, 3, 8'h00, 8'h00, 8'h00);
    add(0, 3'd2,  7, 1, 8'h07, 8'h07, 8'h07);
    add(0, 3'd2, 15, 2, 8'h0F, 8'h0F, 8'h0F);
    add(0, 3'd4,  4, 0, 8'hFF, 8'h00, 8'h00);
    add(0, 3'd4,  5, 0, 8'h00, 8'hFF, 8'h00);
    add(0, 3'd4,  9, 1, 8'h00, 8'hFF, 8'h00);
    add(0, 3'd4, 10, 1, 8'h00, 8'h00, 8'hFF);
    add(0, 3'd5,  3, 1, 8'h00, 8'h00, 8'h00);
    add(0, 3'd7,  0, 0, 8'h00, 8'h00, 8'h00);
    // dut_b: bars 2 px wide with 4 black remainder pixels, 4-bit full scale, thirds at 6/13
    add(1, 3'd0,  0, 0, 8'h0F, 8'h0F, 8'h0F);
    add(1, 3'd0, 12, 0, 8'h00, 8'h00, 8'h0F);
    add(1, 3'd0, 14, 1, 8'h00, 8'h00, 8'h00);
    add(1, 3'd0, 16, 0, 8'h00, 8'h00, 8'h00);
    add(1, 3'd0, 19, 2, 8'h00, 8'h00, 8'h00);
    add(1, 3'd2, 15, 0, 8'h0F, 8'h0F, 8'h0F);
    add(1, 3'd2, 17, 1, 8'h01, 8'h01, 8'h01);
    add(1, 3'd1,  3, 0, 8'h0F, 8'h0F, 8'h0F);
    add(1, 3'd1,  4, 0, 8'h00, 8'h00, 8'h00);
    add(1, 3'd4,  5, 0, 8'h0F, 8'h00, 8'h00);
    add(1, 3'd4,  6, 0, 8'h00, 8'h0F, 8'h00);
    add(1, 3'd4, 12, 2, 8'h00, 8'h0F, 8'h00);
    add(1, 3'd4, 13, 2, 8'h00, 8'h00, 8'h0F);
    add(1, 3'd6,  0, 0, 8'h00, 8'h00, 8'h00);

    sel = 1'b0;
    mode_a = 3'd0;
    mode_b = 3'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    check("run_de_mid_line", 32'(de_a), 32'd1);

    // asynchronous assertion mid-line
    #2 rst_n = 1'b0;
    #1;
    check("rst_de",        32'(de_a), 32'd0);
    check("rst_x",         32'(x_a), 32'd0);
    check("rst_hsync_a",   32'(hsync_a), 32'd0);
    check("rst_vsync_a",   32'(vsync_a), 32'd1);
    check("rst_hsync_b",   32'(hsync_b), 32'd1);
    check("rst_vsync_b",   32'(vsync_b), 32'd0);
    check("rst_rgb",       32'({red_a, green_a, blue_a}), 32'd0);
    check("rst_fs",        32'(frame_start_a), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt_a), 32'd0);

    // moving bar: mode sampled at the very first origin after release
    @(negedge clk);
    mode_a = 3'd3;
    rst_n = 1'b1;
    check("release_fs_before_edge", 32'(frame_start_a), 32'd0);
    @(negedge clk);
    check("first_fs",  32'(frame_start_a), 32'd1);
    check("first_de",  32'(de_a), 32'd1);
    check("first_xy",  32'({x_a, 1'b0, y_a}), 32'd0);
    check("first_fsb", 32'(frame_start_b), 32'd1);

    for (int k = 0; k <= 16; k++) begin
      int first_white, n_white, n_other, bar, exp_cnt;
      if (k > 0) wait_frame("bar");
      if (k < 3 || k >= 14) check($sformatf("bar%0d_frame_cnt", k), 32'(frame_cnt_a), 32'(k));
      first_white = -1; n_white = 0; n_other = 0;
      for (int i = 0; i < 16; i++) begin
        if (red_a == 8'hFF && green_a == 8'hFF && blue_a == 8'hFF) begin
          n_white++;
          if (first_white < 0) first_white = int'(x_a);
        end else if (!(red_a == 8'h00 && green_a == 8'h00 && blue_a == 8'hFF)) begin
          n_other++;
        end
        @(negedge clk);
      end
      bar = k % 16;
      exp_cnt = (16 - bar < 3) ? 16 - bar : 3;
      if (k < 3 || k >= 14) begin
        check($sformatf("bar%0d_first_white", k), 32'(first_white), 32'(bar));
        check($sformatf("bar%0d_white_count", k), 32'(n_white), 32'(exp_cnt));
        check($sformatf("bar%0d_non_blue", k), 32'(n_other), 32'd0);
      end
    end

    // timing over one full frame of dut_a, ramp mode so blanking leaks would show
    begin
      int hs_hi, r1, r2, vs_lo, v1, de_n, blank_bad, fs_n;
      logic hs_prev;
      mode_a = 3'd2;
      do_reset();
      hs_hi = 0; r1 = -1; r2 = -1; vs_lo = 0; v1 = -1; de_n = 0; blank_bad = 0; fs_n = 0;
      hs_prev = 1'b0;
      for (int i = 0; i < 154; i++) begin
        if (hsync_a) hs_hi++;
        if (hsync_a && !hs_prev) begin
          if (r1 < 0) r1 = i;
          else if (r2 < 0) r2 = i;
        end
        hs_prev = hsync_a;
        if (!vsync_a) begin
          vs_lo++;
          if (v1 < 0) v1 = i;
        end
        if (de_a) de_n++;
        if (!de_a && (red_a | green_a | blue_a) != 8'h00) blank_bad++;
        if (frame_start_a) fs_n++;
        @(negedge clk);
      end
      check("hsync_high_per_frame", 32'(hs_hi), 32'd14);
      check("hsync_first_rise",     32'(r1), 32'd18);
      check("hsync_period",         32'(r2 - r1), 32'd22);
      check("vsync_low_count",      32'(vs_lo), 32'd22);
      check("vsync_first_low",      32'(v1), 32'd110);
      check("de_per_frame",         32'(de_n), 32'd64);
      check("blank_rgb_nonzero",    32'(blank_bad), 32'd0);
      check("fs_per_frame",         32'(fs_n), 32'd1);
      check("fs_period",            32'(frame_start_a), 32'd1);
      check("frame_cnt_1",          32'(frame_cnt_a), 32'd1);
      repeat (308) @(negedge clk);
      check("frame_cnt_3",          32'(frame_cnt_a), 32'd3);
      check("fs_after_3_frames",    32'(frame_start_a), 32'd1);
    end

    // polarity and widths of dut_b syncs over one of its frames
    begin
      int hs_lo, vs_hi;
      hs_lo = 0; vs_hi = 0;
      for (int i = 0; i < 182; i++) begin
        if (!hsync_b) hs_lo++;
        if (vsync_b) vs_hi++;
        @(negedge clk);
      end
      check("b_hsync_low_count",  32'(hs_lo), 32'd21);
      check("b_vsync_high_count", 32'(vs_hi), 32'd52);
    end

    // mode change mid-frame takes effect only at the next frame
    sel = 1'b0;
    mode_a = 3'd0;
    wait_frame("latch0");
    wait_pixel("latch_y2", 0, 2);
    mode_a = 3'd1;
    wait_pixel("latch_same", 2, 2);
    check("latch_same_frame_rgb", 32'({s_r, s_g, s_b}), 32'h00FFFF00);
    wait_frame("latch1");
    wait_pixel("latch_next_a", 2, 0);
    check("latch_next_2_0", 32'({s_r, s_g, s_b}), 32'h00000000);
    wait_pixel("latch_next_b", 2, 2);
    check("latch_next_2_2", 32'({s_r, s_g, s_b}), 32'h00FFFFFF);

    // pattern vector table
    for (int i = 0; i < vecs.size(); i++) begin
      sel = vecs[i].sel;
      if (vecs[i].sel) mode_b = vecs[i].md;
      else             mode_a = vecs[i].md;
      wait_frame($sformatf("vec%0d", i));
      wait_pixel($sformatf("vec%0d", i), vecs[i].px, vecs[i].py);
      check($sformatf("vec%0d_red", i),   32'(s_r), 32'(vecs[i].r));
      check($sformatf("vec%0d_green", i), 32'(s_g), 32'(vecs[i].g));
      check($sformatf("vec%0d_blue", i),  32'(s_b), 32'(vecs[i].b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
